// File: rtl/tenkey_pkg.sv
// tenkey_pkg: shared types and key decoding for the tenkey keypad scanner
//   state_t    scanner FSM states
//   KEY_STAR   code of the '*' key (close request)
//   KEY_HASH   code of the '#' key (decoded, no output)
//   KEY_MAP    [row][col] -> key code table
//   key_onehot code -> 10-bit one-hot digit, zero for non-digits
package tenkey_pkg;
   typedef enum logic [1:0] {SCAN, DEB_PRESS, PRESSED, DEB_REL} state_t;
   localparam logic [3:0] KEY_STAR = 4'hA;
   localparam logic [3:0] KEY_HASH = 4'hB;
   localparam logic [3:0] KEY_MAP [0:3][0:2] = '{
      '{4'h1, 4'h2, 4'h3},
      '{4'h4, 4'h5, 4'h6},
      '{4'h7, 4'h8, 4'h9},
      '{KEY_STAR, 4'h0, KEY_HASH}
   };
   function automatic logic [9:0] key_onehot(input logic [3:0] code);
      return (code < 4'd10) ? (10'd1 << code) : '0;
   endfunction
endpackage

// File: rtl/tenkey_sync.sv
// tenkey_sync: two-flop synchroniser for the asynchronous keypad columns
//   ck     in  clock
//   reset  in  asynchronous active-low reset, flops reset to all-ones (idle columns)
//   i_d    in  W asynchronous input bits
//   o_q    out W synchronised bits
module tenkey_sync #(
   parameter int W = 3
) (
   input  logic         ck,
   input  logic         reset,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);
   logic [W-1:0] r_meta;
   logic [W-1:0] r_sync;
   always_ff @(posedge ck or negedge reset)
      if (!reset) begin
         r_meta <= '1;
         r_sync <= '1;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   assign o_q = r_sync;
endmodule

// File: rtl/tenkey_scan.sv
// tenkey_scan: 4x3 keypad scanner with debounce, drives the lock's one-hot tenkey input
//   ck      in   clock
//   reset   in   asynchronous active-low reset
//   col_n   in   3  keypad columns, active-low, asynchronous
//   row_n   out  4  row drive, active-low, one row at a time
//   tenkey  out  10 one-hot digit held while a digit key is down
//   close   out  1  single-cycle pulse on an accepted '*' press
//   beep    out  1  press feedback pulse, present only when TENKEY_BEEP_EN is defined
module tenkey_scan
   import tenkey_pkg::*;
#(
   parameter int SCAN_CYC = 16,
   parameter int DEB_CYC  = 1000
`ifdef TENKEY_BEEP_EN
   ,parameter int BEEP_CYC = 5000
`endif
) (
   input  logic       ck,
   input  logic       reset,
   input  logic [2:0] col_n,
   output logic [3:0] row_n,
   output logic [9:0] tenkey,
   output logic       close
`ifdef TENKEY_BEEP_EN
   ,output logic      beep
`endif
);
   localparam int SW = $clog2(SCAN_CYC);
   localparam int DW = $clog2(DEB_CYC + 1);
   localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_CYC - 1);
   localparam logic [DW-1:0] DEB_FULL  = DW'(DEB_CYC);
   localparam logic [DW-1:0] REL_LAST  = DW'(DEB_CYC - 1);
   state_t        r_state, w_state_nx;
   logic [1:0]    r_row, w_row_nx;
   logic [SW-1:0] r_scnt, w_scnt_nx;
   logic [DW-1:0] r_dcnt, w_dcnt_nx;
   logic [2:0]    r_pat, w_pat_nx;
   logic [1:0]    r_col, w_col_nx;
   logic [9:0]    r_tenkey;
   logic          r_close;
   logic [2:0]    w_cs;
   logic          w_one_low, w_accept, w_release;
   logic [1:0]    w_low_col;
   logic [3:0]    w_code;
   tenkey_sync #(.W(3)) u_sync (.ck(ck), .reset(reset), .i_d(col_n), .o_q(w_cs));
   assign w_one_low = (w_cs == 3'b110) || (w_cs == 3'b101) || (w_cs == 3'b011);
   assign w_low_col = !w_cs[0] ? 2'd0 : !w_cs[1] ? 2'd1 : 2'd2;
   assign w_code    = KEY_MAP[r_row][r_col];
   always_comb begin
      w_state_nx = r_state;
      w_row_nx   = r_row;
      w_scnt_nx  = r_scnt;
      w_dcnt_nx  = r_dcnt;
      w_pat_nx   = r_pat;
      w_col_nx   = r_col;
      w_accept   = 1'b0;
      w_release  = 1'b0;
      case (r_state)
         SCAN:
            if (r_scnt != SCAN_LAST) w_scnt_nx = r_scnt + 1'b1;
            else begin
               w_scnt_nx = '0;
               if (w_one_low) begin
                  w_state_nx = DEB_PRESS;
                  w_pat_nx   = w_cs;
                  w_col_nx   = w_low_col;
                  w_dcnt_nx  = '0;
               end else w_row_nx = r_row + 1'b1;
            end
         // the clock after the last matching sample commits the key
         DEB_PRESS:
            if (r_dcnt == DEB_FULL) begin
               w_state_nx = PRESSED;
               w_accept   = 1'b1;
            end else if (w_cs != r_pat) begin
               w_state_nx = SCAN;
               w_row_nx   = r_row + 1'b1;
            end else w_dcnt_nx = r_dcnt + 1'b1;
         PRESSED:
            if (w_cs != r_pat) begin
               w_state_nx = DEB_REL;
               w_dcnt_nx  = '0;
            end
         // only an unbroken run of all-high samples counts as a release
         default:
            if (w_cs == r_pat) w_state_nx = PRESSED;
            else if (w_cs != 3'b111) w_dcnt_nx = '0;
            else if (r_dcnt == REL_LAST) begin
               w_state_nx = SCAN;
               w_row_nx   = '0;
               w_release  = 1'b1;
            end else w_dcnt_nx = r_dcnt + 1'b1;
      endcase
   end
   always_ff @(posedge ck or negedge reset)
      if (!reset) begin
         r_state  <= SCAN;
         r_row    <= '0;
         r_scnt   <= '0;
         r_dcnt   <= '0;
         r_pat    <= 3'b111;
         r_col    <= '0;
         r_tenkey <= '0;
         r_close  <= 1'b0;
      end else begin
         r_state  <= w_state_nx;
         r_row    <= w_row_nx;
         r_scnt   <= w_scnt_nx;
         r_dcnt   <= w_dcnt_nx;
         r_pat    <= w_pat_nx;
         r_col    <= w_col_nx;
         r_tenkey <= w_accept ? key_onehot(w_code) : w_release ? '0 : r_tenkey;
         r_close  <= w_accept && (w_code == KEY_STAR);
      end
   assign row_n  = ~(4'b0001 << r_row);
   assign tenkey = r_tenkey;
   assign close  = r_close;
`ifdef TENKEY_BEEP_EN
   localparam int BW = $clog2(BEEP_CYC + 1);
   logic [BW-1:0] r_bcnt;
   // '#' produces no output, so it gives no feedback either
   always_ff @(posedge ck or negedge reset)
      if (!reset) r_bcnt <= '0;
      else r_bcnt <= (w_accept && (w_code != KEY_HASH)) ? BW'(BEEP_CYC) :
                     (r_bcnt != '0) ? r_bcnt - 1'b1 : r_bcnt;
   assign beep = (r_bcnt != '0);
`endif
endmodule

// File: tb/tb_tenkey_scan.sv
// tb_tenkey_scan: randomized and directed check of tenkey_scan against a behavioural keypad model
module tb_tenkey_scan;
   localparam int SCAN_CYC = 4;
   localparam int DEB_CYC  = 8;
   localparam int BEEP_CYC = 16;
   logic        ck = 1'b0;
   logic        reset = 1'b1;
   logic [2:0]  col_n;
   logic [3:0]  row_n;
   logic [9:0]  tenkey;
   logic        close;
   logic [11:0] keys = '0;
   int checks = 0;
   int failures = 0;
`ifdef TENKEY_BEEP_EN
   logic beep;
`endif
   tenkey_scan #(
      .SCAN_CYC(SCAN_CYC), .DEB_CYC(DEB_CYC)
`ifdef TENKEY_BEEP_EN
      , .BEEP_CYC(BEEP_CYC)
`endif
   ) dut (
      .ck(ck), .reset(reset), .col_n(col_n), .row_n(row_n), .tenkey(tenkey), .close(close)
`ifdef TENKEY_BEEP_EN
      , .beep(beep)
`endif
   );
   always #5 ck = ~ck;
   // physical keypad: a pressed key shorts its row to its column
   always_comb begin
      col_n = 3'b111;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 3; c++)
            if (!row_n[r] && keys[r*3+c]) col_n[c] = 1'b0;
   end
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask
   function automatic logic [3:0] row_code(input int r);
      return 4'(~(4'b0001 << r));
   endfunction
   // behavioural model: phase, elapsed clocks in phase, expected outputs
   int kmap [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 0, 11};
   int m_row = 0, m_mode = 0, m_t = 0, m_key = 0, e_beep = 0;
   logic [2:0] m_pat = 3'b111, m_s1 = 3'b111, m_cs = 3'b111, smp;
   logic [9:0] e_ten = '0, prev_ten = '0;
   logic e_close = 1'b0, rst_smp;
   task automatic model_reset();
      m_row = 0; m_mode = 0; m_t = 0; m_pat = 3'b111; m_s1 = 3'b111; m_cs = 3'b111;
      e_ten = '0; e_close = 1'b0; e_beep = 0;
   endtask
   task automatic model_step(input logic [2:0] cs);
      int col;
      e_close = 1'b0;
      if (e_beep > 0) e_beep--;
      case (m_mode)
         0: begin
            m_t++;
            if (m_t == SCAN_CYC) begin
               m_t = 0;
               if ($countones(~cs) == 1) begin
                  col = !cs[0] ? 0 : !cs[1] ? 1 : 2;
                  m_pat = cs; m_mode = 1; m_key = kmap[m_row*3 + col];
               end else m_row = (m_row + 1) % 4;
            end
         end
         1: begin
            if (m_t == DEB_CYC) begin
               m_mode = 2;
               if (m_key < 10) e_ten = 10'd1 << m_key;
               e_close = (m_key == 10);
               if (m_key != 11) e_beep = BEEP_CYC;
            end else if (cs != m_pat) begin
               m_mode = 0; m_t = 0; m_row = (m_row + 1) % 4;
            end else m_t++;
         end
         2: if (cs != m_pat) begin m_mode = 3; m_t = 0; end
         default: begin
            if (cs == m_pat) m_mode = 2;
            else if (cs == 3'b111) begin
               m_t++;
               if (m_t == DEB_CYC) begin m_mode = 0; m_t = 0; m_row = 0; e_ten = '0; end
            end else m_t = 0;
         end
      endcase
   endtask
   initial begin
      forever begin
         @(negedge ck);
         chk("row_n", row_n, row_code(m_row));
         chk("tenkey", tenkey, e_ten);
         chk("close", close, e_close);
`ifdef TENKEY_BEEP_EN
         chk("beep", beep, e_beep > 0);
`endif
         chk("onehot", $countones(tenkey) <= 1, 1);
         chk("digit_hop", (prev_ten != '0) && (tenkey != '0) && (tenkey != prev_ten), 0);
         prev_ten = tenkey;
         #4;
         smp = col_n;
         rst_smp = reset;
         @(posedge ck);
         if (!rst_smp) model_reset();
         else begin
            model_step(m_cs);
            m_cs = m_s1;
            m_s1 = smp;
         end
      end
   end
   int ten_rises = 0, close_cyc = 0, row_chg = 0, beep_rises = 0, beep_cyc = 0;
   logic [9:0] mon_ten = '0;
   logic [3:0] mon_row = 4'b1110;
   logic mon_beep = 1'b0;
   always @(negedge ck) begin
      ten_rises <= ten_rises + (((mon_ten == '0) && (tenkey != '0)) ? 1 : 0);
      close_cyc <= close_cyc + (close ? 1 : 0);
      row_chg   <= row_chg + ((row_n != mon_row) ? 1 : 0);
      mon_ten   <= tenkey;
      mon_row   <= row_n;
`ifdef TENKEY_BEEP_EN
      beep_rises <= beep_rises + ((!mon_beep && beep) ? 1 : 0);
      beep_cyc   <= beep_cyc + (beep ? 1 : 0);
      mon_beep   <= beep;
`endif
   end
   task automatic do_reset();
      @(negedge ck); #2 reset = 1'b0;
      repeat (2) @(negedge ck);
      #2 reset = 1'b1;
   endtask
   task automatic wait_ten(output int k);
      k = 0;
      while (tenkey == '0 && k < 100) begin @(negedge ck); k++; end
   endtask
   int k, r0, c0, b0, bc0, g0;
   logic [11:0] rk;
   initial begin
      #1 reset = 1'b0;
      repeat (3) @(negedge ck);
      chk("rst_row_n", row_n, 4'b1110);
      chk("rst_tenkey", tenkey, 0);
      chk("rst_close", close, 0);
      #2 reset = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         @(negedge ck);
         chk("row_walk", row_n, row_code((i / 4) % 4));
      end
      keys = 12'h010;
      do_reset();
      wait_ten(k);
      chk("press5_latency", k, 17);
      chk("press5_code", tenkey, 10'b00_0010_0000);
      repeat (39) @(negedge ck);
      chk("press5_held", tenkey, 10'b00_0010_0000);
      #2 keys = '0;
      k = 0;
      while (tenkey != '0 && k < 100) begin @(negedge ck); k++; end
      chk("release5_latency", k, 11);
      repeat (20) @(negedge ck);
      #2 r0 = ten_rises;
      for (int i = 0; i < 3; i++) begin
         keys = 12'h004; @(negedge ck); #2 keys = '0; @(negedge ck); #2;
      end
      chk("bounce3_quiet", ten_rises - r0, 0);
      keys = 12'h004;
      repeat (80) @(negedge ck);
      #2 chk("bounce3_once", ten_rises - r0, 1);
      chk("bounce3_code", tenkey, 10'b00_0000_1000);
      keys = '0;
      repeat (30) @(negedge ck);
      #2 c0 = close_cyc; r0 = ten_rises;
      keys = 12'h200;
      repeat (60) @(negedge ck);
      #2 chk("star_close_cycles", close_cyc - c0, 1);
      chk("star_no_tenkey", ten_rises - r0, 0);
      keys = '0;
      repeat (30) @(negedge ck);
      #2 c0 = close_cyc; r0 = ten_rises; b0 = beep_rises;
      keys = 12'h800;
      repeat (60) @(negedge ck);
      #2 chk("hash_no_close", close_cyc - c0, 0);
      chk("hash_no_tenkey", ten_rises - r0, 0);
      chk("hash_no_beep", beep_rises - b0, 0);
      keys = '0;
      repeat (30) @(negedge ck);
      #2 c0 = close_cyc; r0 = ten_rises; g0 = row_chg;
      keys = 12'h003;
      repeat (60) @(negedge ck);
      #2 chk("dual_no_tenkey", ten_rises - r0, 0);
      chk("dual_no_close", close_cyc - c0, 0);
      chk("dual_scanning", (row_chg - g0) > 8, 1);
      keys = '0;
      repeat (20) @(negedge ck);
      #2 keys = 12'h100;
      wait_ten(k);
      chk("press9_code", tenkey, 10'b10_0000_0000);
      repeat (3) @(negedge ck);
      #2 reset = 1'b0;
      #1 chk("midrst_tenkey", tenkey, 0);
      chk("midrst_row_n", row_n, 4'b1110);
      keys = '0;
      repeat (2) @(negedge ck);
      #2 reset = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         @(negedge ck);
         chk("rescan_walk", row_n, row_code((i / 4) % 4));
      end
`ifdef TENKEY_BEEP_EN
      repeat (10) @(negedge ck);
      #2 b0 = beep_rises; bc0 = beep_cyc;
      keys = 12'h040;
      wait_ten(k);
      chk("beep7_code", tenkey, 10'b00_1000_0000);
      chk("beep7_with_tenkey", beep, 1);
      repeat (40) @(negedge ck);
      #2 chk("beep7_length", beep_cyc - bc0, 16);
      keys = '0;
      repeat (3) @(negedge ck);
      #2 keys = 12'h040;
      repeat (3) @(negedge ck);
      #2 keys = '0;
      repeat (30) @(negedge ck);
      #2 chk("beep7_single", beep_rises - b0, 1);
      chk("beep7_released", tenkey, 0);
`endif
      for (int ep = 0; ep < 30; ep++) begin
         rk = 12'd1 << $urandom_range(0, 11);
         if ($urandom_range(0, 4) == 0) rk = rk | (12'd1 << $urandom_range(0, 11));
         for (int i = 0; i < int'($urandom_range(0, 3)); i++) begin
            keys = rk; repeat ($urandom_range(1, 5)) @(negedge ck);
            #2 keys = '0; repeat ($urandom_range(1, 5)) @(negedge ck);
            #2;
         end
         keys = rk;
         repeat ($urandom_range(5, 60)) @(negedge ck);
         #2;
         for (int i = 0; i < int'($urandom_range(0, 2)); i++) begin
            keys = '0; repeat ($urandom_range(1, 6)) @(negedge ck);
            #2 keys = rk; repeat ($urandom_range(1, 4)) @(negedge ck);
            #2;
         end
         keys = '0;
         repeat ($urandom_range(5, 40)) @(negedge ck);
         #2;
         if ($urandom_range(0, 9) == 0) begin
            reset = 1'b0; repeat (2) @(negedge ck);
            #2 reset = 1'b1;
         end
      end
      repeat (5) @(negedge ck);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
   initial begin
      #1_000_000;
      failures++;
      $display("FAIL watchdog: got timeout expected finish at %0t", $time);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
